trace_halt_unit: RTL and testbench
==================================

# trace_halt_unit

Synthesizable run-control and trace block for the multi-cycle MIPS CPU. It records committed PC/instruction pairs in a parametrised circular buffer and counts run cycles. On a cycle limit or a PC breakpoint it stalls the CPU, walks the register file, and streams every register out for checking. It sits beside `CPU`, observing its PC/instruction and borrowing a register-file read port only while halted.

## Interface
- `ADDR_W`, 32, PC width
- `DATA_W`, 32, instruction and register data width
- `DEPTH`, 16, trace entries; power of two, ≥2
- `CNT_W`, 16, cycle-counter width
- `NUM_REGS`, 32, registers dumped; power of two
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `commit`  in  1  CPU retired an instruction this cycle
- `pc`  in  ADDR_W  PC of committing instruction
- `inst`  in  DATA_W  committing instruction word
- `cycle_limit`  in  CNT_W  run-cycle budget; 0 = unlimited
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  ADDR_W  breakpoint PC
- `cpu_stall`  out  1  freeze CPU state updates
- `halt_cause`  out  2  bit0 = cycle limit, bit1 = breakpoint
- `rf_raddr`  out  log2(NUM_REGS)  register-file read address (async read)
- `rf_rdata`  in  DATA_W  register-file read data
- `dump_valid`  out  1  `dump_idx`/`dump_data` valid
- `dump_idx`  out  log2(NUM_REGS)  register index
- `dump_data`  out  DATA_W  register value
- `done`  out  1  dump complete
- `tr_count`  out  log2(DEPTH)+1  valid trace entries
- `tr_idx`  in  log2(DEPTH)  trace read index, 0 = oldest
- `tr_data`  out  ADDR_W+DATA_W  `{pc, inst}` at `tr_idx`

## Operation
- States: RUN, DUMP, HALTED. Reset enters RUN.
- RUN, every cycle:
  - `cycle_cnt` increments.
  - With `commit`=1: write `{pc,inst}` at `wr_ptr`; `wr_ptr` wraps mod DEPTH; `tr_count` saturates at DEPTH.
  - With `commit`=0: nothing recorded.
- Halt triggers in RUN; each sets its `halt_cause` bit:
  - limit: `cycle_limit`≠0 and `cycle_cnt`+1 == `cycle_limit`.
  - breakpoint: `commit` & `bp_en` & `pc`==`bp_addr`. The breakpoint instruction is still recorded.
  - Both in the same cycle set both bits. Any trigger moves RUN→DUMP.
- DUMP:
  - `rf_raddr` steps 0..NUM_REGS-1, one per cycle.
  - Next cycle, `dump_valid`=1 with registered `dump_idx` and `dump_data`; `dump_data` is forced 0 for index 0.
  - After the last address is issued: DUMP→HALTED.
- HALTED: `done`=1. Terminal until `rst`.
- `cpu_stall`=1 in DUMP and HALTED. No commits are recorded outside RUN.
- Trace read:
  - Physical entry is (`wr_ptr` − `tr_count` + `tr_idx`) mod DEPTH.
  - `tr_data` is registered; `tr_idx` ≥ `tr_count` yields 0.
  - Readable in every state.
- `rst` mid-DUMP or in HALTED returns to RUN and clears all state. Trace storage contents need not clear; `tr_count`=0 masks them.

## Timing
- Reset values:
  - `cpu_stall`=0, `halt_cause`=0, `rf_raddr`=0
  - `dump_valid`=0, `dump_idx`=0, `dump_data`=0, `done`=0
  - `tr_count`=0, `tr_data`=0
  - internal `cycle_cnt`=0, `wr_ptr`=0
- Trigger in cycle T: `cpu_stall` and `halt_cause` are valid from T+1. First `dump_valid` appears at T+2.
- Dump: `dump_valid` is high for exactly NUM_REGS consecutive cycles, T+2..T+NUM_REGS+1.
- `done` rises at T+NUM_REGS+2, the cycle after the last `dump_valid`.
- `tr_data` latency: 1 cycle from `tr_idx`.
- Counter widths:
  - `cycle_cnt` is CNT_W bits and freezes outside RUN.
  - With `cycle_limit`=0 it wraps silently.

## Structure
- `trace_pkg`: state enum (RUN/DUMP/HALTED), `CAUSE_LIMIT`=0 and `CAUSE_BP`=1 bit indices, trace entry width function.
- Sub-module `trace_ring`: DEPTH×(ADDR_W+DATA_W) circular buffer owning `wr_ptr`, `tr_count`, and the registered oldest-relative read.
- Top: FSM, cycle counter, trigger logic, dump sequencer.

## Test plan
- `cycle_limit`=30, `bp_en`=0, `commit`=1 every cycle, `pc`=0x3000+4k:
  - `cpu_stall` rises 31 cycles after reset release; `halt_cause`=01.
  - `tr_count`=16; `tr_idx`=0 gives pc 0x3038; `tr_idx`=15 gives pc 0x3074.
- `cycle_limit`=0, `bp_en`=1, `bp_addr`=0x300C, same stream:
  - halt after the 4th commit; `halt_cause`=10; `tr_count`=4; `tr_idx`=3 gives pc 0x300C.
- Dump with the register-file model returning 0x100+addr:
  - 32 consecutive `dump_valid` cycles with `dump_idx` 0..31.
  - Register 0 reads 0; register 5 reads 0x105; `done`=1 in the next cycle.
- `cycle_limit`=4 with `bp_addr` matching the commit in cycle 3: `halt_cause`=11.
- `commit` toggling 1,0,1,0 with `cycle_limit`=8: halt at the 8th cycle; `tr_count`=4.
- `rst` pulsed while `dump_idx`=10:
  - the next cycle shows all outputs at reset values and `cpu_stall`=0.
  - a new run records from `tr_count`=0.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and helpers for the trace/halt unit
package trace_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DUMP   = 2'd1,
        HALTED = 2'd2
    } state_t;

    // bit positions inside halt_cause
    localparam int CAUSE_LIMIT = 0;
    localparam int CAUSE_BP    = 1;

    // one trace entry holds {pc, inst}
    function automatic int entry_w(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/trace_ring.sv
// rtl/trace_ring.sv - circular {pc,inst} trace buffer with oldest-relative registered read
// Ports: clk, rst (sync, active-high); wr_en/wr_data append an entry;
//        tr_count = valid entries (saturates at DEPTH);
//        tr_idx -> tr_data one cycle later, 0 = oldest, out-of-range reads 0.
module trace_ring #(
    parameter int DEPTH = 16,
    parameter int EW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [EW-1:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0]   tr_idx,
    output logic [$clog2(DEPTH):0]     tr_count,
    output logic [EW-1:0]              tr_data
);
    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_phys;

    // Oldest entry sits tr_count slots behind wr_ptr; when full the low bits
    // of tr_count are zero so the oldest entry is wr_ptr itself.
    assign rd_phys = wr_ptr - tr_count[AW-1:0] + tr_idx;

    // Storage is not reset: tr_count=0 masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            tr_count <= '0;
            tr_data  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (tr_count != (AW+1)'(DEPTH)) begin
                    tr_count <= tr_count + (AW+1)'(1);
                end
            end
            tr_data <= ({1'b0, tr_idx} < tr_count) ? mem[rd_phys] : '0;
        end
    end

endmodule

// File: rtl/trace_halt_unit.sv
// rtl/trace_halt_unit.sv - run-control: trace capture, cycle/breakpoint halt, register dump
// Ports: clk, rst (sync, active-high); commit/pc/inst observe the CPU;
//        cycle_limit (0 = unlimited), bp_en/bp_addr halt triggers;
//        cpu_stall/halt_cause report the halt; rf_raddr/rf_rdata borrow a
//        register-file read port; dump_valid/dump_idx/dump_data stream the
//        registers; done marks the end; tr_count/tr_idx/tr_data read the trace.
module trace_halt_unit #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16,
    parameter int NUM_REGS = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          commit,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [DATA_W-1:0]             inst,
    input  logic [CNT_W-1:0]              cycle_limit,
    input  logic                          bp_en,
    input  logic [ADDR_W-1:0]             bp_addr,
    output logic                          cpu_stall,
    output logic [1:0]                    halt_cause,
    output logic [$clog2(NUM_REGS)-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]             rf_rdata,
    output logic                          dump_valid,
    output logic [$clog2(NUM_REGS)-1:0]   dump_idx,
    output logic [DATA_W-1:0]             dump_data,
    output logic                          done,
    output logic [$clog2(DEPTH):0]        tr_count,
    input  logic [$clog2(DEPTH)-1:0]      tr_idx,
    output logic [ADDR_W+DATA_W-1:0]      tr_data
);
    import trace_pkg::*;

    localparam int RW = $clog2(NUM_REGS);
    localparam int EW = entry_w(ADDR_W, DATA_W);

    state_t           state;
    logic [CNT_W-1:0] cycle_cnt;
    logic             lim_hit;
    logic             bp_hit;
    logic             rec_en;
    logic [1:0]       trig_cause;

    // Limit fires on the cycle whose count would reach the budget, so the
    // CPU runs exactly cycle_limit cycles before the stall takes effect.
    assign lim_hit = (state == RUN) && (cycle_limit != '0)
                     && ((cycle_cnt + CNT_W'(1)) == cycle_limit);
    assign bp_hit  = (state == RUN) && commit && bp_en && (pc == bp_addr);
    // The breakpoint instruction itself is still recorded.
    assign rec_en  = (state == RUN) && commit;

    always_comb begin
        trig_cause              = '0;
        trig_cause[CAUSE_LIMIT] = lim_hit;
        trig_cause[CAUSE_BP]    = bp_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cycle_cnt  <= '0;
            cpu_stall  <= 1'b0;
            halt_cause <= '0;
            rf_raddr   <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (trig_cause != 2'b00) begin
                        state      <= DUMP;
                        cpu_stall  <= 1'b1;
                        halt_cause <= trig_cause;
                    end
                end
                DUMP: begin
                    // rf read is asynchronous: capture data for the address
                    // presented this cycle, then advance.
                    dump_valid <= 1'b1;
                    dump_idx   <= rf_raddr;
                    dump_data  <= (rf_raddr == '0) ? '0 : rf_rdata;
                    rf_raddr   <= rf_raddr + RW'(1);
                    if (rf_raddr == RW'(NUM_REGS - 1)) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    dump_valid <= 1'b0;
                    done       <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    trace_ring #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rec_en),
        .wr_data  ({pc, inst}),
        .tr_idx   (tr_idx),
        .tr_count (tr_count),
        .tr_data  (tr_data)
    );

endmodule

// File: tb/tb_trace_halt_unit.sv
// tb/tb_trace_halt_unit.sv - scoreboard bench for trace_halt_unit
module tb_trace_halt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] cycle_limit;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_stall;
    logic [1:0]  halt_cause;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        done;
    logic [4:0]  tr_count;
    logic [3:0]  tr_idx;
    logic [63:0] tr_data;

    int errors = 0;
    int checks = 0;

    logic [63:0] tq[$];   // expected trace contents, oldest first
    logic [36:0] dq[$];   // expected dump beats {idx, data}

    always #5 clk = ~clk;

    assign rf_rdata = 32'h100 + {27'b0, rf_raddr};

    trace_halt_unit dut (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .pc          (pc),
        .inst        (inst),
        .cycle_limit (cycle_limit),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cpu_stall   (cpu_stall),
        .halt_cause  (halt_cause),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .dump_valid  (dump_valid),
        .dump_idx    (dump_idx),
        .dump_data   (dump_data),
        .done        (done),
        .tr_count    (tr_count),
        .tr_idx      (tr_idx),
        .tr_data     (tr_data)
    );

    task automatic test_reset();
        rst = 1'b1; commit = 1'b0; pc = '0; inst = '0; tr_idx = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_stall, halt_cause, rf_raddr, dump_valid, dump_idx, dump_data, done} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got stall=%b cause=%b raddr=%0d dv=%b idx=%0d data=%h done=%b, want all 0",
                     cpu_stall, halt_cause, rf_raddr, dump_valid, dump_idx, dump_data, done);
        end
        checks++;
        if ({tr_count, tr_data} !== '0) begin
            errors++;
            $display("FAIL reset_trace: got tr_count=%0d tr_data=%h, want 0", tr_count, tr_data);
        end
        tq.delete();
        rst = 1'b0;
    endtask

    // Drives the commit stream from the first post-reset cycle until cpu_stall
    // is seen; k is the cycle number of the trigger.
    task automatic run_stream(input bit toggle, output int k);
        logic [31:0] pcv;
        bit stalled;
        pcv = 32'h3000; stalled = 1'b0; k = 0;
        while (!stalled && k < 200) begin
            k++;
            commit = toggle ? (k % 2 == 1) : 1'b1;
            pc     = pcv;
            inst   = 32'hA500_0000 ^ pcv;
            if (commit) begin
                tq.push_back({pc, inst});
                if (tq.size() > 16) void'(tq.pop_front());
                pcv += 4;
            end
            @(negedge clk);
            stalled = cpu_stall;
        end
        commit = 1'b0;
        if (!stalled) begin
            checks++; errors++;
            $display("FAIL stall_timeout: cpu_stall never rose within %0d cycles", k);
        end
    endtask

    task automatic check_trace(input string name);
        checks++;
        if (tr_count !== 5'(tq.size())) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, tr_count, tq.size());
        end
        for (int i = 0; i < tq.size(); i++) begin
            tr_idx = 4'(i);
            @(negedge clk);
            checks++;
            if (tr_data !== tq[i]) begin
                errors++;
                $display("FAIL %s_entry%0d: got %h want %h", name, i, tr_data, tq[i]);
            end
        end
        if (tq.size() < 16) begin
            tr_idx = 4'(tq.size());
            @(negedge clk);
            checks++;
            if (tr_data !== 64'h0) begin
                errors++;
                $display("FAIL %s_out_of_range: got %h want 0", name, tr_data);
            end
        end
    endtask

    task automatic check_pc_at(input string name, input int idx, input logic [31:0] want);
        tr_idx = 4'(idx);
        @(negedge clk);
        checks++;
        if (tr_data[63:32] !== want) begin
            errors++;
            $display("FAIL %s: got pc %h want %h", name, tr_data[63:32], want);
        end
    endtask

    // Called on the first cycle cpu_stall is seen.
    task automatic check_dump();
        int first, last, n, done_c;
        logic [36:0] exp;
        first = -1; last = -1; n = 0; done_c = -1;
        for (int r = 0; r < 32; r++) dq.push_back({5'(r), (r == 0) ? 32'h0 : 32'h100 + r});
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dump_valid) begin
                if (first < 0) first = c;
                last = c; n++;
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL dump_extra: unexpected beat idx=%0d data=%h", dump_idx, dump_data);
                end else begin
                    exp = dq.pop_front();
                    if ({dump_idx, dump_data} !== exp) begin
                        errors++;
                        $display("FAIL dump_beat: got idx=%0d data=%h want idx=%0d data=%h",
                                 dump_idx, dump_data, exp[36:32], exp[31:0]);
                    end
                end
            end
            if (done && done_c < 0) done_c = c;
        end
        checks++;
        if (first != 1 || last != 32 || n != 32) begin
            errors++;
            $display("FAIL dump_window: got first=%0d last=%0d beats=%0d want 1,32,32", first, last, n);
        end
        checks++;
        if (done_c != 33) begin
            errors++;
            $display("FAIL done_timing: got cycle %0d want 33", done_c);
        end
        dq.delete();
    endtask

    task automatic test_limit();
        int k;
        test_reset();
        cycle_limit = 16'd30; bp_en = 1'b0; bp_addr = 32'h3008;
        run_stream(1'b0, k);
        checks++;
        if (k != 30) begin errors++; $display("FAIL limit_stall_cycle: got %0d want 30", k); end
        checks++;
        if (halt_cause !== 2'b01) begin errors++; $display("FAIL limit_cause: got %b want 01", halt_cause); end
        check_dump();
        check_trace("limit");
        check_pc_at("limit_oldest_pc", 0, 32'h3038);
        check_pc_at("limit_newest_pc", 15, 32'h3074);
        // commits while halted must not be recorded
        commit = 1'b1; pc = 32'h4000;
        repeat (3) @(negedge clk);
        commit = 1'b0;
        checks++;
        if ({tr_count, cpu_stall, done} !== {5'd16, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL halted_hold: got count=%0d stall=%b done=%b want 16,1,1", tr_count, cpu_stall, done);
        end
    endtask

    task automatic test_breakpoint();
        int k;
        test_reset();
        cycle_limit = 16'd0; bp_en = 1'b1; bp_addr = 32'h300C;
        run_stream(1'b0, k);
        checks++;
        if (k != 4) begin errors++; $display("FAIL bp_stall_cycle: got %0d want 4", k); end
        checks++;
        if (halt_cause !== 2'b10) begin errors++; $display("FAIL bp_cause: got %b want 10", halt_cause); end
        check_trace("bp");
        check_pc_at("bp_last_pc", 3, 32'h300C);
    endtask

    task automatic test_both();
        int k;
        test_reset();
        cycle_limit = 16'd4; bp_en = 1'b1; bp_addr = 32'h300C;
        run_stream(1'b0, k);
        checks++;
        if (k != 4 || halt_cause !== 2'b11) begin
            errors++;
            $display("FAIL both_cause: got cycle=%0d cause=%b want 4,11", k, halt_cause);
        end
    endtask

    task automatic test_toggle();
        int k;
        test_reset();
        cycle_limit = 16'd8; bp_en = 1'b0;
        run_stream(1'b1, k);
        checks++;
        if (k != 8) begin errors++; $display("FAIL toggle_stall_cycle: got %0d want 8", k); end
        check_trace("toggle");
    endtask

    task automatic test_reset_mid_dump();
        int k;
        bit hit;
        test_reset();
        cycle_limit = 16'd5; bp_en = 1'b0;
        run_stream(1'b0, k);
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            hit = dump_valid && (dump_idx == 5'd10);
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL mid_dump_timeout: dump_idx 10 never seen");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_stall, halt_cause, rf_raddr, dump_valid, dump_idx, dump_data, done, tr_count, tr_data} !== '0) begin
            errors++;
            $display("FAIL mid_dump_reset: got stall=%b cause=%b raddr=%0d dv=%b idx=%0d data=%h done=%b cnt=%0d tr=%h, want all 0",
                     cpu_stall, halt_cause, rf_raddr, dump_valid, dump_idx, dump_data, done, tr_count, tr_data);
        end
        tq.delete();
        rst = 1'b0;
        cycle_limit = 16'd3;
        run_stream(1'b0, k);
        checks++;
        if (k != 3) begin errors++; $display("FAIL rerun_stall_cycle: got %0d want 3", k); end
        check_trace("rerun");
    endtask

    initial begin
        rst = 1'b1; commit = 1'b0; pc = '0; inst = '0;
        cycle_limit = '0; bp_en = 1'b0; bp_addr = '0; tr_idx = '0;
        test_limit();
        test_breakpoint();
        test_both();
        test_toggle();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
